// File: rtl/ssd_page_if.sv
// rtl/ssd_page_if.sv - bus bundle between the requesters, the page scheduler and the SSD driver
interface ssd_page_if #(
  parameter int SOURCES = 4,
  parameter int PW      = (SOURCES > 1) ? $clog2(SOURCES) : 1
);
  logic [SOURCES*16-1:0] src_data;
  logic [SOURCES-1:0]    src_valid;
  logic                  auto_en;
  logic                  step;
  logic                  urgent_req;
  logic [15:0]           urgent_data;
  logic                  urgent_ack;
  logic [15:0]           number;
  logic [PW-1:0]         page;
  logic                  number_valid;

  modport master (
    output src_data, src_valid, auto_en, step, urgent_req, urgent_data,
    input  urgent_ack, number, page, number_valid
  );

  modport slave (
    input  src_data, src_valid, auto_en, step, urgent_req, urgent_data,
    output urgent_ack, number, page, number_valid
  );
endinterface

// File: rtl/ssd_page_scheduler.sv
// rtl/ssd_page_scheduler.sv - page rotation and urgent preemption for the shared seven-segment display (optional SSD_PAGE_TAG_EN)
module ssd_page_scheduler #(
  parameter int SOURCES     = 4,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  ssd_page_if.slave   bus
);
  localparam int PW = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam int CW = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, SHOW, URGENT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] page_q, page_d;
  logic [15:0]   number_q, number_d;
  logic          valid_q, valid_d;
  logic          ack_q, ack_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    step_sync_q, step_sync_d;

  logic [PW-1:0] next_page;
  logic [PW-1:0] first_page;
  logic [PW-1:0] cand;
  logic          found;
  logic          any_valid;
  logic          step_edge;
  logic          expire;

  // Word presented on the display for a given source; tagged build puts the page index in the top digit
  function automatic logic [15:0] show_val(input logic [SOURCES*16-1:0] d, input logic [PW-1:0] p);
    logic [15:0] w;
    logic [3:0]  tag;
    w   = d[16*int'(p) +: 16];
    tag = 4'(p);
`ifdef SSD_PAGE_TAG_EN
    return {tag, w[11:0]};
`else
    tag = 4'd0;
    return w | {tag, 12'd0};
`endif
  endfunction

  // Candidate pages: next valid above the current one (wrapping) and the lowest valid overall
  always_comb begin
    next_page  = page_q;
    first_page = '0;
    cand       = '0;
    found      = 1'b0;
    for (int k = 1; k <= SOURCES; k++) begin
      cand = PW'((int'(page_q) + k) % SOURCES);
      if (!found && bus.src_valid[cand]) begin
        next_page = cand;
        found     = 1'b1;
      end
    end
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (bus.src_valid[i]) first_page = PW'(i);
    end
  end

  assign any_valid   = |bus.src_valid;
  assign step_edge   = step_sync_q[1] & ~step_sync_q[2];
  assign expire      = bus.auto_en && (cnt_q == CW'(HOLD_CYCLES - 1));
  assign step_sync_d = {step_sync_q[1:0], bus.step};

  // Next-state and registered-output logic; urgent beats all-invalid beats step/timer
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    number_d = 16'd0;
    valid_d  = 1'b0;
    ack_d    = 1'b0;
    cnt_d    = '0;
    if (bus.urgent_req) begin
      state_d  = URGENT;
      ack_d    = (state_q != URGENT);
      number_d = bus.urgent_data;
      valid_d  = 1'b1;
    end else if (!any_valid) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = SHOW;
          page_d   = first_page;
          number_d = show_val(bus.src_data, first_page);
          valid_d  = 1'b1;
        end
        URGENT: begin
          state_d  = SHOW;
          number_d = show_val(bus.src_data, page_q);
          valid_d  = 1'b1;
        end
        default: begin
          valid_d = 1'b1;
          if (!bus.src_valid[page_q] || step_edge || expire) begin
            page_d   = next_page;
            number_d = show_val(bus.src_data, next_page);
          end else begin
            number_d = show_val(bus.src_data, page_q);
            cnt_d    = bus.auto_en ? cnt_q + CW'(1) : '0;
          end
        end
      endcase
    end
  end

  // State, output and synchroniser registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      page_q      <= '0;
      number_q    <= 16'd0;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      cnt_q       <= '0;
      step_sync_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      number_q    <= number_d;
      valid_q     <= valid_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      step_sync_q <= step_sync_d;
    end
  end

  assign bus.number       = number_q;
  assign bus.page         = page_q;
  assign bus.number_valid = valid_q;
  assign bus.urgent_ack   = ack_q;
endmodule

// File: tb/tb_ssd_page_scheduler.sv
// tb/tb_ssd_page_scheduler.sv - directed self-checking bench for ssd_page_scheduler
module tb_ssd_page_scheduler;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  ssd_page_if #(.SOURCES(4)) bus ();

  ssd_page_scheduler #(.SOURCES(4), .HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expn(input int p);
    logic [15:0] w;
    w = {4'(p + 1), 4'(p + 1), 4'(p + 1), 4'(p + 1)};
`ifdef SSD_PAGE_TAG_EN
    w[15:12] = 4'(p);
`endif
    return w;
  endfunction

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst_n           = 1'b0;
    bus.src_data    = '0;
    bus.src_valid   = '0;
    bus.auto_en     = 1'b0;
    bus.step        = 1'b0;
    bus.urgent_req  = 1'b0;
    bus.urgent_data = 16'h0000;
    tick();
    tick();
    check("rst_number", bus.number, 16'h0000);
    check("rst_page",   16'(bus.page), 16'd0);
    check("rst_valid",  16'(bus.number_valid), 16'd0);
    check("rst_ack",    16'(bus.urgent_ack), 16'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_valid",  16'(bus.number_valid), 16'd0);
    check("idle_number", bus.number, 16'h0000);

    // Auto rotation over four valid sources
    bus.src_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bus.src_valid = 4'b1111;
    bus.auto_en   = 1'b1;
    tick();
    check("auto_first_page",  16'(bus.page), 16'd0);
    check("auto_first_num",   bus.number, expn(0));
    check("auto_first_valid", 16'(bus.number_valid), 16'd1);
    for (int p = 1; p <= 4; p++) begin
      repeat (3) tick();
      check("auto_hold_page", 16'(bus.page), 16'((p - 1) % 4));
      tick();
      check("auto_adv_page", 16'(bus.page), 16'(p % 4));
      check("auto_adv_num",  bus.number, expn(p % 4));
    end

    // Asynchronous reset in the middle of SHOW
    rst_n = 1'b0;
    #1;
    check("mid_rst_number", bus.number, 16'h0000);
    check("mid_rst_page",   16'(bus.page), 16'd0);
    check("mid_rst_valid",  16'(bus.number_valid), 16'd0);
    bus.src_valid = 4'b1010;
    #1;
    rst_n = 1'b1;

    // Skip and wrap over sparse valid sources
    tick();
    check("skip_first_page", 16'(bus.page), 16'd1);
    check("skip_first_num",  bus.number, expn(1));
    for (int r = 0; r < 3; r++) begin
      repeat (4) tick();
      check("skip_page", 16'(bus.page), (r % 2 == 0) ? 16'd3 : 16'd1);
    end
    bus.src_valid = 4'b0010;
    tick();
    check("drop_page", 16'(bus.page), 16'd1);
    check("drop_num",  bus.number, expn(1));
    bus.src_valid = 4'b0000;
    tick();
    check("all_drop_valid",  16'(bus.number_valid), 16'd0);
    check("all_drop_number", bus.number, 16'h0000);
    check("all_drop_page",   16'(bus.page), 16'd1);

    // Manual step, held button gives a single advance
    bus.src_valid = 4'b1111;
    bus.auto_en   = 1'b0;
    tick();
    check("step_start_page", 16'(bus.page), 16'd0);
    bus.step = 1'b1;
    tick();
    tick();
    check("step_early_page", 16'(bus.page), 16'd0);
    tick();
    check("step_adv_page", 16'(bus.page), 16'd1);
    check("step_adv_num",  bus.number, expn(1));
    repeat (17) tick();
    check("step_held_page", 16'(bus.page), 16'd1);
    bus.step = 1'b0;
    repeat (3) tick();

    // Step edge coinciding with timer expiry
    bus.auto_en = 1'b1;
    tick();
    bus.step = 1'b1;
    tick();
    tick();
    check("coin_before_page", 16'(bus.page), 16'd1);
    tick();
    check("coin_adv_page", 16'(bus.page), 16'd2);
    check("coin_adv_num",  bus.number, expn(2));
    repeat (3) tick();
    check("coin_single_page", 16'(bus.page), 16'd2);
    bus.auto_en = 1'b0;
    bus.step    = 1'b0;
    repeat (3) tick();

    // Urgent preemption while showing page 2
    bus.urgent_data = 16'hBEEF;
    bus.urgent_req  = 1'b1;
    tick();
    check("urg_ack",    16'(bus.urgent_ack), 16'd1);
    check("urg_number", bus.number, 16'hBEEF);
    check("urg_page",   16'(bus.page), 16'd2);
    check("urg_valid",  16'(bus.number_valid), 16'd1);
    bus.step = 1'b1;
    tick();
    check("urg_ack_pulse", 16'(bus.urgent_ack), 16'd0);
    repeat (5) tick();
    check("urg_step_page", 16'(bus.page), 16'd2);
    check("urg_step_num",  bus.number, 16'hBEEF);
    bus.urgent_data = 16'hCAFE;
    tick();
    check("urg_track_num", bus.number, 16'hCAFE);
    bus.urgent_req = 1'b0;
    bus.auto_en    = 1'b1;
    tick();
    check("rel_page", 16'(bus.page), 16'd2);
    check("rel_num",  bus.number, expn(2));
    check("rel_ack",  16'(bus.urgent_ack), 16'd0);
    repeat (3) tick();
    check("rel_hold_page", 16'(bus.page), 16'd2);
    tick();
    check("rel_adv_page", 16'(bus.page), 16'd3);

    // Re-entry gives a fresh acknowledge, then reset while in URGENT
    bus.urgent_req = 1'b1;
    tick();
    check("reent1_ack", 16'(bus.urgent_ack), 16'd1);
    bus.urgent_req = 1'b0;
    tick();
    check("reent_show_ack", 16'(bus.urgent_ack), 16'd0);
    bus.urgent_req = 1'b1;
    tick();
    check("reent2_ack", 16'(bus.urgent_ack), 16'd1);
    rst_n = 1'b0;
    #1;
    check("urg_rst_ack",    16'(bus.urgent_ack), 16'd0);
    check("urg_rst_number", bus.number, 16'h0000);
    check("urg_rst_page",   16'(bus.page), 16'd0);
    check("urg_rst_valid",  16'(bus.number_valid), 16'd0);
    bus.urgent_req = 1'b0;
    bus.src_valid  = 4'b0000;
    bus.step       = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_idle", 16'(bus.number_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
